core_dispatch_scoreboard: RTL

CORE_DISPATCH_SCOREBOARD -- requirements
Module: core_dispatch_scoreboard

---
 rtl/core_dispatch_scoreboard_pkg.sv | 43 ++++
 rtl/core_dispatch_scoreboard_entry.sv | 51 +++++
 rtl/core_dispatch_scoreboard.sv | 133 +++++++++++++
 3 files changed

// File: rtl/core_dispatch_scoreboard_pkg.sv
// Shared core micro-architecture types for the dispatch scoreboard.
//   hword         : 16-bit half-word
//   reg_idx_t     : architectural register index (REG_IDX_W bits)
//   eu_class_e    : execution-unit class of a decoded instruction
//   insn_decode   : one decoded instruction as presented to dispatch
//   disp_state_e  : dispatch FSM states
//   max_u()       : constant helper for sizing latency counters
package core_dispatch_scoreboard_pkg;

    localparam int unsigned REG_IDX_W = 4;

    typedef logic [15:0]          hword;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        EU_ALU    = 2'd0,
        EU_MUL    = 2'd1,
        EU_LDST   = 2'd2,
        EU_BRANCH = 2'd3
    } eu_class_e;

    typedef struct packed {
        logic      valid;    // slot holds an instruction (0 = bubble)
        logic      execute;  // instruction is ready to leave decode
        eu_class_e eu;
        logic      rd_we;    // writes rd
        reg_idx_t  rd;
        logic      ra_used;
        reg_idx_t  ra;
        logic      rb_used;
        reg_idx_t  rb;
    } insn_decode;

    typedef enum logic {
        IDLE    = 1'b0,
        BR_WAIT = 1'b1
    } disp_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_dispatch_scoreboard_entry.sv
// One scoreboard entry: busy bit plus latency down-counter for a single register.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   set         : a writer to this register is dispatched this cycle
//   set_lat     : latency to load (0 = load/store, cleared by writeback only)
//   wb_clr      : load writeback targeting this register
//   busy        : registered busy bit
//   raw_hazard  : a reader of this register must be held this cycle
// Macro CORE_SCOREBOARD_FORWARD_EN: a result one cycle from completion is
// bypassable, so it stops counting as a read hazard.
module core_dispatch_scoreboard_entry #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [CNT_W-1:0] set_lat,
    input  logic             wb_clr,
    output logic             busy,
    output logic             raw_hazard
);

    logic [CNT_W-1:0] cnt;

    // A new write takes priority over an expiry or writeback in the same cycle.
    // Timed writers clear on the count reaching zero; load writers (count 0)
    // clear only on a matching writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (set) begin
            busy <= 1'b1;
            cnt  <= set_lat;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end else if (busy && wb_clr) begin
            busy <= 1'b0;
        end
    end

`ifdef CORE_SCOREBOARD_FORWARD_EN
    assign raw_hazard = busy && (cnt != CNT_W'(1));
`else
    assign raw_hazard = busy;
`endif

endmodule

// File: rtl/core_dispatch_scoreboard.sv
// In-order multi-lane dispatch with a per-register write scoreboard.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   lane            : ISSUE_WIDTH decoded instructions, lane 0 oldest
//   branch_stall    : hold all dispatch
//   flush           : squash this cycle's dispatch, leave branch-wait
//   ldst_wb_valid/rd: load writeback completion
//   branch_done     : branch unit has resolved the outstanding branch
//   dispatch        : per-lane grant
//   busy_mask       : registers with a pending write (registered)
// Macro CORE_SCOREBOARD_FORWARD_EN: enables one-cycle-early RAW release
// (implemented in core_dispatch_scoreboard_entry).
module core_dispatch_scoreboard
    import core_dispatch_scoreboard_pkg::*;
#(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned LAT_ALU     = 1,
    parameter int unsigned LAT_MUL     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  insn_decode                  lane [ISSUE_WIDTH],
    input  logic                        branch_stall,
    input  logic                        flush,
    input  logic                        ldst_wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] ldst_wb_rd,
    input  logic                        branch_done,
    output logic [ISSUE_WIDTH-1:0]      dispatch,
    output logic [NUM_REGS-1:0]         busy_mask
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = $clog2(max_u(LAT_ALU, LAT_MUL) + 1);

    disp_state_e         state, state_nxt;
    logic                grant_en;
    logic                br_granted;
    logic [NUM_REGS-1:0] raw_hazard;
    logic [NUM_REGS-1:0] set_busy;
    logic [NUM_REGS-1:0] wb_clr;
    logic [CNT_W-1:0]    set_lat [NUM_REGS];

    assign grant_en = !(rst || flush || branch_stall) && (state == IDLE);

    // Walk lanes oldest to youngest. A refused valid lane stops all younger
    // lanes; a bubble is skipped so younger valid lanes may still go (the
    // in-order prefix holds over valid lanes). 'claimed' carries rd of older
    // writers granted this cycle for same-cycle RAW/WAW.
    always_comb begin : grant
        logic                blocked;
        logic                mul_used;
        logic                ldst_used;
        logic                ok;
        logic [NUM_REGS-1:0] claimed;

        dispatch   = '0;
        br_granted = 1'b0;
        set_busy   = '0;
        set_lat    = '{default: '0};
        blocked    = 1'b0;
        mul_used   = 1'b0;
        ldst_used  = 1'b0;
        ok         = 1'b0;
        claimed    = '0;

        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            if (grant_en && !blocked && lane[i].valid) begin
                ok = lane[i].execute;
                if (lane[i].ra_used && (raw_hazard[lane[i].ra] || claimed[lane[i].ra])) ok = 1'b0;
                if (lane[i].rb_used && (raw_hazard[lane[i].rb] || claimed[lane[i].rb])) ok = 1'b0;
                if (lane[i].rd_we && (busy_mask[lane[i].rd] || claimed[lane[i].rd]))    ok = 1'b0;
                if ((lane[i].eu == EU_MUL)  && mul_used)  ok = 1'b0;
                if ((lane[i].eu == EU_LDST) && ldst_used) ok = 1'b0;

                if (ok) begin
                    dispatch[i] = 1'b1;
                    if (lane[i].rd_we) begin
                        claimed[lane[i].rd]  = 1'b1;
                        set_busy[lane[i].rd] = 1'b1;
                        case (lane[i].eu)
                            EU_MUL:  set_lat[lane[i].rd] = CNT_W'(LAT_MUL);
                            EU_LDST: set_lat[lane[i].rd] = '0;
                            default: set_lat[lane[i].rd] = CNT_W'(LAT_ALU);
                        endcase
                    end
                    if (lane[i].eu == EU_MUL)  mul_used  = 1'b1;
                    if (lane[i].eu == EU_LDST) ldst_used = 1'b1;
                    if (lane[i].eu == EU_BRANCH) begin
                        br_granted = 1'b1;
                        blocked    = 1'b1;  // branch must be the youngest grant
                    end
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (br_granted)            state_nxt = BR_WAIT;
            BR_WAIT: if (branch_done || flush)  state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        assign wb_clr[r] = ldst_wb_valid && (ldst_wb_rd == IDX_W'(r));

        core_dispatch_scoreboard_entry #(
            .CNT_W(CNT_W)
        ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .set        (set_busy[r]),
            .set_lat    (set_lat[r]),
            .wb_clr     (wb_clr[r]),
            .busy       (busy_mask[r]),
            .raw_hazard (raw_hazard[r])
        );
    end

endmodule
